ppu_sprite_eval: RTL and testbench

- Per-scanline sprite evaluation controller for the PPU.
- Owns the 256-byte primary OAM port during evaluation. It scans all 64 sprites and copies up to 8 in-range sprites into an internal 32-byte secondary OAM.
- Reports sprite count, sprite-0 presence and overflow.
- Sits between the primary OAM (combinational read, synchronous write) and the sprite pattern fetch logic. The fetch logic reads secondary OAM through a dedicated read port.

---
 rtl/ppu_sprite_eval_pkg.sv | 38 +++
 rtl/ppu_sec_oam.sv | 24 ++
 rtl/ppu_sprite_eval.sv | 171 +++++++++++++++++
 tb/tb_ppu_sprite_eval.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_sprite_eval_pkg.sv
// Shared types and constants for the per-scanline sprite evaluator.
package ppu_sprite_eval_pkg;

   localparam int unsigned OAM_SPRITES   = 64;
   localparam int unsigned SEC_SLOTS     = 8;
   localparam int unsigned SEC_OAM_BYTES = 32;
   localparam int unsigned SPRITE_H8     = 8;
   localparam int unsigned SPRITE_H16    = 16;

   localparam int unsigned SPR_IDX_W  = $clog2(OAM_SPRITES);
   localparam int unsigned SLOT_W     = $clog2(SEC_SLOTS);
   localparam int unsigned SEC_ADDR_W = $clog2(SEC_OAM_BYTES);
   localparam int unsigned CNT_W      = SLOT_W + 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_CHECK,
      ST_COPY,
      ST_SCAN_OVF,
      ST_DONE
   } sprite_eval_state_t;

   typedef struct packed {
      logic                  we;
      logic [SEC_ADDR_W-1:0] addr;
      logic [7:0]            data;
   } sec_wr_t;

   // A sprite covers rows Y..Y+h-1; a negative distance (Y below scanline) is a miss.
   function automatic logic y_in_range(input logic [7:0] scanline, input logic [7:0] y,
                                       input logic h16);
      logic [8:0] diff;
      diff = {1'b0, scanline} - {1'b0, y};
      return !diff[8] && (diff[7:0] < (h16 ? 8'(SPRITE_H16) : 8'(SPRITE_H8)));
   endfunction

endpackage

// File: rtl/ppu_sec_oam.sv
// 32x8 secondary OAM: one synchronous write port, one combinational read port.
module ppu_sec_oam
   import ppu_sprite_eval_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  sec_wr_t               wr,
   input  logic [SEC_ADDR_W-1:0] raddr,
   output logic [7:0]            rdata_c
);

   logic [7:0] mem_q [SEC_OAM_BYTES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(SEC_OAM_BYTES); i++) mem_q[i] <= 8'hFF;
      end else if (wr.we) begin
         mem_q[wr.addr] <= wr.data;
      end
   end

   assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/ppu_sprite_eval.sv
// Scanline sprite evaluation: clears secondary OAM, scans primary OAM for in-range
// sprites, copies up to eight of them and flags sprite 0 and overflow.
module ppu_sprite_eval
   import ppu_sprite_eval_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [7:0]            scanline_i,
   input  logic                  sprite_h16_i,
   output logic                  oam_req_o,
   output logic [7:0]            oam_addr_o,
   input  logic [7:0]            oam_data_i,
   input  logic [SEC_ADDR_W-1:0] sec_addr_i,
   output logic [7:0]            sec_data_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [CNT_W-1:0]      sprite_count_o,
   output logic                  sprite0_hit_o,
   output logic                  overflow_o
);

   sprite_eval_state_t state_q, state_d;

   logic [7:0]            scanline_q;
   logic                  h16_q;
   logic [SPR_IDX_W-1:0]  n_q;
   logic [SEC_ADDR_W-1:0] c_q;
   logic [1:0]            b_q;
   logic [CNT_W-1:0]      count_q;
   logic                  sprite0_q;
   logic                  overflow_q;

   logic    hit;
   logic    last_sprite;
   sec_wr_t sec_wr;

   assign hit         = y_in_range(scanline_q, oam_data_i, h16_q);
   assign last_sprite = (n_q == SPR_IDX_W'(OAM_SPRITES - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start_i) state_d = ST_CLEAR;
         ST_CLEAR: if (c_q == SEC_ADDR_W'(SEC_OAM_BYTES - 1)) state_d = ST_CHECK;
         ST_CHECK: begin
            if (hit)              state_d = ST_COPY;
            else if (last_sprite) state_d = ST_DONE;
         end
         ST_COPY: begin
            if (b_q == 2'd3) begin
               if (last_sprite)                             state_d = ST_DONE;
               else if (count_q == CNT_W'(SEC_SLOTS - 1))   state_d = ST_SCAN_OVF;
               else                                         state_d = ST_CHECK;
            end
         end
         ST_SCAN_OVF: if (hit || last_sprite) state_d = ST_DONE;
         ST_DONE:     state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Output and secondary-OAM write decode
   always_comb begin
      busy_o      = 1'b0;
      done_o      = 1'b0;
      oam_req_o   = 1'b0;
      sec_wr      = '0;
      unique case (state_q)
         ST_CLEAR: begin
            busy_o      = 1'b1;
            sec_wr.we   = 1'b1;
            sec_wr.addr = c_q;
            sec_wr.data = 8'hFF;
         end
         ST_CHECK: begin
            busy_o      = 1'b1;
            oam_req_o   = 1'b1;
            sec_wr.we   = hit;
            sec_wr.addr = {count_q[SLOT_W-1:0], 2'b00};
            sec_wr.data = oam_data_i;
         end
         ST_COPY: begin
            busy_o      = 1'b1;
            oam_req_o   = 1'b1;
            sec_wr.we   = 1'b1;
            sec_wr.addr = {count_q[SLOT_W-1:0], b_q};
            sec_wr.data = oam_data_i;
         end
         ST_SCAN_OVF: begin
            busy_o    = 1'b1;
            oam_req_o = 1'b1;
         end
         ST_DONE: done_o = 1'b1;
         default: ;
      endcase
   end

   // Datapath: latched request, sprite/byte/clear indices and result flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scanline_q <= '0;
         h16_q      <= 1'b0;
         n_q        <= '0;
         c_q        <= '0;
         b_q        <= '0;
         count_q    <= '0;
         sprite0_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  scanline_q <= scanline_i;
                  h16_q      <= sprite_h16_i;
                  n_q        <= '0;
                  c_q        <= '0;
                  b_q        <= '0;
                  count_q    <= '0;
                  sprite0_q  <= 1'b0;
                  overflow_q <= 1'b0;
               end
            end
            ST_CLEAR: c_q <= c_q + SEC_ADDR_W'(1);
            ST_CHECK: begin
               if (hit) begin
                  b_q <= 2'd1;
                  if (n_q == '0) sprite0_q <= 1'b1;
               end else if (!last_sprite) begin
                  n_q <= n_q + SPR_IDX_W'(1);
               end
            end
            ST_COPY: begin
               if (b_q == 2'd3) begin
                  b_q     <= 2'd0;
                  count_q <= count_q + CNT_W'(1);
                  if (!last_sprite) n_q <= n_q + SPR_IDX_W'(1);
               end else begin
                  b_q <= b_q + 2'd1;
               end
            end
            ST_SCAN_OVF: begin
               if (hit)               overflow_q <= 1'b1;
               else if (!last_sprite) n_q <= n_q + SPR_IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign oam_addr_o     = {n_q, b_q};
   assign sprite_count_o = count_q;
   assign sprite0_hit_o  = sprite0_q;
   assign overflow_o     = overflow_q;

   ppu_sec_oam u_sec_oam (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (sec_wr),
      .raddr   (sec_addr_i),
      .rdata_c (sec_data_o)
   );

endmodule

// File: tb/tb_ppu_sprite_eval.sv
// Randomized and directed bench for ppu_sprite_eval against a list-based sprite model.
module tb_ppu_sprite_eval;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] scanline;
   logic       h16;
   logic       oam_req;
   logic [7:0] oam_addr;
   logic [7:0] oam_data;
   logic [4:0] sec_addr;
   logic [7:0] sec_data;
   logic       busy;
   logic       done;
   logic [3:0] count;
   logic       s0hit;
   logic       ovf;

   logic [7:0] oam_mem [256];

   int n_tests = 0;
   int n_fail  = 0;

   // model expectations
   int         exp_cnt, exp_s0, exp_ovf, exp_lat;
   logic [7:0] exp_sec [32];
   // captured DUT results of the last run
   int         res_cnt, res_s0, res_ovf, res_lat, res_maxrd;
   logic [7:0] res_sec [32];

   always #5 clk = ~clk;

   assign oam_data = oam_mem[oam_addr];

   ppu_sprite_eval dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start_i        (start),
      .scanline_i     (scanline),
      .sprite_h16_i   (h16),
      .oam_req_o      (oam_req),
      .oam_addr_o     (oam_addr),
      .oam_data_i     (oam_data),
      .sec_addr_i     (sec_addr),
      .sec_data_o     (sec_data),
      .busy_o         (busy),
      .done_o         (done),
      .sprite_count_o (count),
      .sprite0_hit_o  (s0hit),
      .overflow_o     (ovf)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Walk the sprite list: in-range sprites fill slots in order, a ninth ends the scan.
   task automatic model_eval(input int sl, input bit hh);
      int hits, checked, ht, d;
      ht = hh ? 16 : 8;
      hits = 0; checked = 64; exp_s0 = 0; exp_ovf = 0;
      for (int i = 0; i < 32; i++) exp_sec[i] = 8'hFF;
      for (int s = 0; s < 64; s++) begin
         d = sl - int'(oam_mem[s*4]);
         if (d >= 0 && d < ht) begin
            if (hits == 8) begin
               exp_ovf = 1;
               checked = s + 1;
               break;
            end
            for (int k = 0; k < 4; k++) exp_sec[hits*4+k] = oam_mem[s*4+k];
            if (s == 0) exp_s0 = 1;
            hits++;
         end
      end
      exp_cnt = hits;
      exp_lat = 33 + checked + 3 * exp_cnt;
   endtask

   task automatic read_sec();
      for (int a = 0; a < 32; a++) begin
         sec_addr = 5'(a);
         #1;
         res_sec[a] = sec_data;
      end
   endtask

   task automatic clear_oam();
      for (int i = 0; i < 256; i++) oam_mem[i] = ((i % 4) == 0) ? 8'hF0 : 8'(i);
   endtask

   task automatic run_eval(input logic [7:0] sl, input logic hh, input bit extra_start);
      int cyc;
      bit busy_bad;
      model_eval(int'(sl), hh);
      @(negedge clk);
      scanline = sl; h16 = hh; start = 1'b1;
      @(negedge clk);
      start = 1'b0; scanline = 8'($urandom); h16 = 1'($urandom);
      cyc = 1; busy_bad = 0; res_maxrd = -1;
      while (!done && cyc < 1000) begin
         if (!busy) busy_bad = 1;
         if (oam_req && int'(oam_addr) > res_maxrd) res_maxrd = int'(oam_addr);
         @(negedge clk);
         start = (extra_start && (cyc == 40 || cyc == 60)) ? 1'b1 : 1'b0;
         cyc++;
      end
      start = 1'b0;
      res_lat = cyc;
      chk("done_latency", res_lat, exp_lat);
      chk("busy_during_eval", int'(busy_bad), 0);
      chk("busy_at_done", int'(busy), 0);
      @(negedge clk);
      chk("done_one_cycle", int'(done), 0);
      res_cnt = int'(count); res_s0 = int'(s0hit); res_ovf = int'(ovf);
      chk("sprite_count", res_cnt, exp_cnt);
      chk("sprite0_hit", res_s0, exp_s0);
      chk("overflow", res_ovf, exp_ovf);
      read_sec();
      for (int a = 0; a < 32; a++) chk($sformatf("sec_byte_%0d", a), int'(res_sec[a]), int'(exp_sec[a]));
   endtask

   task automatic fill_random(input logic [7:0] sl, input int dens);
      for (int s = 0; s < 64; s++) begin
         if ($urandom_range(0, 63) < dens) oam_mem[s*4] = sl - 8'($urandom_range(0, 17));
         else                              oam_mem[s*4] = 8'($urandom);
         for (int k = 1; k < 4; k++) oam_mem[s*4+k] = 8'($urandom);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; scanline = '0; h16 = 1'b0; sec_addr = '0;
      clear_oam();
      repeat (3) @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_oam_req", int'(oam_req), 0);
      chk("reset_oam_addr", int'(oam_addr), 0);
      chk("reset_count", int'(count), 0);
      sec_addr = 5'd17; #1;
      chk("reset_sec17", int'(sec_data), 8'hFF);
      rst_n = 1'b1;

      // 1: nothing in range
      clear_oam();
      run_eval(8'd100, 1'b0, 1'b0);
      chk("t1_latency_literal", res_lat, 97);
      chk("t1_count_literal", res_cnt, 0);
      chk("t1_sec31_literal", int'(res_sec[31]), 8'hFF);

      // 2: sprite 0 in range
      clear_oam();
      oam_mem[0] = 8'd96; oam_mem[1] = 8'h11; oam_mem[2] = 8'h22; oam_mem[3] = 8'h33;
      run_eval(8'd100, 1'b0, 1'b0);
      chk("t2_latency_literal", res_lat, 100);
      chk("t2_s0_literal", res_s0, 1);
      chk("t2_sec0_literal", int'(res_sec[0]), 8'h60);
      chk("t2_sec3_literal", int'(res_sec[3]), 8'h33);

      // 3: height selects whether a 10-row distance hits
      clear_oam();
      oam_mem[20] = 8'd90;
      run_eval(8'd100, 1'b0, 1'b0);
      chk("t3_h8_count_literal", res_cnt, 0);
      run_eval(8'd100, 1'b1, 1'b0);
      chk("t3_h16_count_literal", res_cnt, 1);
      chk("t3_h16_sec0_literal", int'(res_sec[0]), 90);
      chk("t3_h16_s0_literal", res_s0, 0);

      // 4: overflow stops the scan at sprite 8
      clear_oam();
      for (int s = 0; s < 10; s++) oam_mem[s*4] = 8'd100;
      run_eval(8'd100, 1'b0, 1'b0);
      chk("t4_count_literal", res_cnt, 8);
      chk("t4_ovf_literal", res_ovf, 1);
      chk("t4_last_read_literal", res_maxrd, 32);

      // 5: range boundaries at scanline 10
      clear_oam(); oam_mem[0] = 8'd11;
      run_eval(8'd10, 1'b0, 1'b0);
      chk("t5_neg_literal", res_cnt, 0);
      clear_oam(); oam_mem[0] = 8'd3;
      run_eval(8'd10, 1'b0, 1'b0);
      chk("t5_diff7_literal", res_cnt, 1);
      clear_oam(); oam_mem[0] = 8'd2;
      run_eval(8'd10, 1'b0, 1'b0);
      chk("t5_diff8_literal", res_cnt, 0);
      run_eval(8'd17, 1'b1, 1'b0);
      chk("t5_h16_diff15_literal", res_cnt, 1);
      run_eval(8'd18, 1'b1, 1'b0);
      chk("t5_h16_diff16_literal", res_cnt, 0);

      // 6: reset in the middle of a copy, then a run with ignored start pulses
      clear_oam();
      oam_mem[0] = 8'd100; oam_mem[4] = 8'd98; oam_mem[5] = 8'hA5;
      @(negedge clk);
      scanline = 8'd100; h16 = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (34) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", int'(busy), 0);
      chk("t6_rst_oam_req", int'(oam_req), 0);
      chk("t6_rst_oam_addr", int'(oam_addr), 0);
      chk("t6_rst_count", int'(count), 0);
      chk("t6_rst_s0", int'(s0hit), 0);
      chk("t6_rst_done", int'(done), 0);
      read_sec();
      chk("t6_rst_sec0", int'(res_sec[0]), 8'hFF);
      chk("t6_rst_sec1", int'(res_sec[1]), 8'hFF);
      @(negedge clk);
      rst_n = 1'b1;
      run_eval(8'd100, 1'b0, 1'b1);
      chk("t6_count_literal", res_cnt, 2);
      chk("t6_latency_literal", res_lat, 103);

      // randomized sweep
      for (int t = 0; t < 24; t++) begin
         logic [7:0] sl;
         logic       hh;
         sl = 8'($urandom_range(0, 239));
         hh = 1'($urandom);
         fill_random(sl, int'($urandom_range(0, 18)));
         run_eval(sl, hh, (t % 4) == 3);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
